// File: rtl/pe_accumulate_pkg.sv
// Shared types and constants for the PE accumulation stage.
package pe_accumulate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic        MODE_INT      = 1'b0;
    localparam logic        MODE_FP       = 1'b1;
    localparam logic [15:0] FP16_ZERO     = 16'h0000;
    localparam logic [15:0] FP16_QNAN     = 16'h7E00;
    localparam int          LEN_W_DEFAULT = 8;

endpackage

// File: rtl/pe_accumulate_if.sv
// Command, product-input and result-output signals of the accumulation stage.
interface pe_accumulate_if #(
    parameter int LEN_W = pe_accumulate_pkg::LEN_W_DEFAULT
);
    logic             start;
    logic             mode;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic             out_mode;
    logic             busy;

    modport master (
        output start, mode, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_mode, busy
    );

    modport slave (
        input  start, mode, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_mode, busy
    );
endinterface

// File: rtl/pe_accumulate_int_fp_add.sv
// Combined INT16 / FP16 adder, single-cycle combinational form.
module int_fp_add
    import pe_accumulate_pkg::*;
(
    input  logic        mode_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);

    logic [11:0] int_lo;
    logic [4:0]  int_hi;
    logic [15:0] int_sum;

    // 11-bit low slice carries into the 5-bit high slice.
    assign int_lo  = {1'b0, a_i[10:0]} + {1'b0, b_i[10:0]};
    assign int_hi  = a_i[15:11] + b_i[15:11] + {4'b0, int_lo[11]};
    assign int_sum = {int_hi, int_lo[10:0]};

    logic [15:0] x, y, fp_sum;
    logic [4:0]  ex, ey, d;
    logic [13:0] xe, ye, ys;
    logic [14:0] s;
    logic [6:0]  e;
    logic [11:0] mr;
    logic        st, inc, a_nan, b_nan, a_inf, b_inf;

    always_comb begin
        a_nan = (a_i[14:10] == 5'h1f) && (a_i[9:0] != '0);
        b_nan = (b_i[14:10] == 5'h1f) && (b_i[9:0] != '0);
        a_inf = (a_i[14:10] == 5'h1f) && (a_i[9:0] == '0);
        b_inf = (b_i[14:10] == 5'h1f) && (b_i[9:0] == '0);

        if (a_i[14:0] >= b_i[14:0]) begin
            x = a_i;
            y = b_i;
        end else begin
            x = b_i;
            y = a_i;
        end
        ex = (x[14:10] == '0) ? 5'd1 : x[14:10];
        ey = (y[14:10] == '0) ? 5'd1 : y[14:10];
        xe = {(x[14:10] != '0), x[9:0], 3'b000};
        ye = {(y[14:10] != '0), y[9:0], 3'b000};
        d  = ex - ey;

        // Bits shifted out of the smaller operand collapse into a sticky bit.
        st = 1'b0;
        for (int unsigned i = 0; i < 14; i++) begin
            if (i < 32'(d)) st = st | ye[i];
        end
        ys    = (d >= 5'd14) ? '0 : (ye >> d);
        ys[0] = ys[0] | st;

        if (x[15] == y[15]) s = {1'b0, xe} + {1'b0, ys};
        else                s = {1'b0, xe} - {1'b0, ys};

        e = {2'b00, ex};
        if (s[14]) begin
            s = {1'b0, s[14:2], s[1] | s[0]};
            e = e + 7'd1;
        end
        for (int unsigned i = 0; i < 13; i++) begin
            if (!s[13] && (e > 7'd1)) begin
                s = s << 1;
                e = e - 7'd1;
            end
        end

        inc = s[2] & (s[1] | s[0] | s[3]);
        mr  = {1'b0, s[13:3]} + {11'b0, inc};
        if (mr[11]) begin
            mr = mr >> 1;
            e  = e + 7'd1;
        end

        if (a_nan || b_nan || (a_inf && b_inf && (a_i[15] != b_i[15])))
            fp_sum = FP16_QNAN;
        else if (a_inf)
            fp_sum = a_i;
        else if (b_inf)
            fp_sum = b_i;
        else if (s == '0)
            fp_sum = FP16_ZERO;
        else if (e >= 7'd31)
            fp_sum = {x[15], 5'h1f, 10'h000};
        else
            fp_sum = {x[15], (mr[10] ? e[4:0] : 5'd0), mr[9:0]};
    end

    assign sum_o = (mode_i == MODE_FP) ? fp_sum : int_sum;

endmodule

// File: rtl/pe_accumulate.sv
// Accumulates a run of len products through int_fp_add and presents the sum.
module pe_accumulate
    import pe_accumulate_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    pe_accumulate_if.slave bus
);

    state_e           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             mode_q, mode_d;
    logic [15:0]      add_sum;
    logic             in_ready_c, out_valid_c, busy_c, launch;

    int_fp_add u_add (
        .mode_i (mode_q),
        .a_i    (bus.in_data),
        .b_i    (acc_q),
        .sum_o  (add_sum)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        mode_d      = mode_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        launch      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                launch = bus.start;
            end
            ST_ACC: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b1;
                if (bus.in_valid) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid_c = 1'b1;
                busy_c      = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                    launch  = bus.start;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A start taken on the output handshake behaves exactly like one from IDLE.
        if (launch) begin
            mode_d  = bus.mode;
            len_d   = bus.len;
            acc_d   = FP16_ZERO;
            cnt_d   = '0;
            state_d = (bus.len == '0) ? ST_HOLD : ST_ACC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= MODE_INT;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.out_data  = acc_q;
    assign bus.out_mode  = mode_q;

endmodule

// File: doc/pe_accumulate.md
# pe_accumulate

Processing-element accumulation stage that sits directly downstream of the multiplier and wraps the combined INT/FP16 adder (`int_fp_add`) in a feedback loop. It sums a run of `len` 16-bit products into a running partial sum and presents the final sum on a valid/ready output. It supports INT mode (16-bit wrapping add) and FP16 mode (FP16 add). The adder is used in its single-cycle combinational form, so one term is accumulated per cycle.

## Interface
- `LEN_W`, default 8: width of the term-count input.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  begin a new accumulation. Honoured only in IDLE, or in HOLD on the same cycle as the output handshake.
- `mode`  in  1  sampled with `start`. 0 = INT (wrapping 16-bit add), 1 = FP16.
- `len`  in  LEN_W  number of terms, sampled with `start`. 0 means an empty sum.
- `in_valid`  in  1  a product is present on `in_data`.
- `in_ready`  out  1  the block accepts a product this cycle.
- `in_data`  in  16  product (INT: 16-bit two's complement; FP: FP16).
- `out_valid`  out  1  the final sum is present.
- `out_ready`  in  1  the consumer takes the sum.
- `out_data`  out  16  final sum (the registered accumulator).
- `out_mode`  out  1  mode latched for this result.
- `busy`  out  1  the block is in ACC or HOLD.

## Operation
- States:
  - IDLE: waits for `start`.
  - ACC: accepts terms.
  - HOLD: presents the result.
- Registers: `acc`[15:0], `cnt`[LEN_W-1:0], `len_q`, `mode_q`.
- IDLE with `start`=1:
  - Latch `mode` and `len`; clear `acc` and `cnt` to 0.
  - If `len`≠0, go to ACC. If `len`=0, go to HOLD with `acc`=16'h0000.
- ACC:
  - `in_ready`=1.
  - On each `in_valid`&&`in_ready`: `acc` ← adder(`mode_q`, `acc`, `in_data`) and `cnt`++.
  - When the accepted beat has `cnt`==`len_q`-1, go to HOLD.
  - If `in_valid`=0, nothing changes.
  - `start` in ACC is ignored.
- HOLD:
  - `out_valid`=1 and `in_ready`=0; `out_data`/`out_mode` stay stable until the handshake.
  - On `out_valid`&&`out_ready`: go to IDLE, or, if `start`=1 on the same cycle, go directly to the new operation exactly as from IDLE (back-to-back, no bubble).
- Adder connection: operand a = `in_data`, operand b = `acc`, mode pin = `mode_q`.
  - INT result is `acc`+`in_data` mod 2^16 (11-bit low add carrying into the 5-bit high add).
  - FP result follows adder semantics. +0 (16'h0000) is the seed and must be an identity for normal operands.
- `rst` asserted at any time, including mid-ACC: immediately return to IDLE and clear all registers. The partial sum is discarded and no output is produced.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=16'h0000, `out_mode`=0, `busy`=0.
- `start` accepted in cycle T: state is ACC (or HOLD for `len`=0) at T+1, with `in_ready`=1 (or `out_valid`=1) from T+1.
- Last term accepted in cycle N: `out_valid`=1 at N+1, with `out_data` holding the complete sum.
- With `in_valid` held high, `len`=L takes L ACC cycles, so the result appears L+1 cycles after `start`.
- `in_ready` and `out_valid` are driven from state only; neither depends combinationally on `in_valid` or `out_ready`.
- `out_ready` may stay low indefinitely. HOLD persists with all outputs frozen.
- `len`=2^LEN_W-1 is the maximum run. `cnt` never wraps because the compare terminates first.

## Structure
- Shared package holds:
  - State encoding for IDLE, ACC and HOLD.
  - `MODE_INT`=1'b0 and `MODE_FP`=1'b1.
  - `FP16_ZERO`=16'h0000.
  - Default `LEN_W`.
- One sub-module: `int_fp_add`, instantiated with the pipeline define off.
- FSM, counter, accumulator and handshake logic are in `pe_accumulate`.

## Test plan
- INT, `len`=4, terms 1,2,3,4 with `in_valid` held: `out_data`=16'h000A and `out_mode`=0, asserted 5 cycles after `start`.
- INT wrap, `len`=2, terms 16'hFFFF and 16'h0002: `out_data`=16'h0001.
- FP, `len`=3, terms 16'h3C00 (1.0), 16'h3C00 (1.0), 16'h4000 (2.0): `out_data`=16'h4400 (4.0) and `out_mode`=1.
- `len`=0: `out_valid`=1 one cycle after `start` with `out_data`=16'h0000; `in_ready` never asserts.
- Back-pressure plus back-to-back:
  - `out_ready` low for 5 cycles: `out_data` is stable and `in_ready`=0 throughout.
  - `start` on the handshake cycle: `in_ready`=1 on the next cycle and the new sum is correct.
- Reset mid-ACC: assert `rst` after 2 of 4 INT terms. All outputs return to reset values at once. A following `start` with `len`=1 and term 7 gives `out_data`=16'h0007.
